// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one shared column mixer walks the four columns
// of the 128-bit state, one column per clock, with valid/ready on both sides.
module mix_columns_seq #(
    parameter int BYTE = 8,
    parameter int WORD = 32,
    parameter int Nb   = 128,
    parameter int NCOL = Nb / WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          bypass,
    input  logic [Nb-1:0] state_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [Nb-1:0] state_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [Nb-1:0]   data_q, data_d;
    logic [WORD-1:0] col_word_s;
    logic [WORD-1:0] mixed_word_s;
    logic [Nb-1:0]   data_mixed_s;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] a);
        return {a[BYTE-2:0], 1'b0} ^ (a[BYTE-1] ? 8'h1b : 8'h00);
    endfunction

    // a0 is the most significant byte of the column
    function automatic logic [WORD-1:0] col_mix(input logic [WORD-1:0] c);
        logic [BYTE-1:0] a0, a1, a2, a3;
        a0 = c[4*BYTE-1 -: BYTE];
        a1 = c[3*BYTE-1 -: BYTE];
        a2 = c[2*BYTE-1 -: BYTE];
        a3 = c[BYTE-1 -: BYTE];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Select the current column, mix it, and splice it back into the state
    always_comb begin
        col_word_s   = '0;
        data_mixed_s = data_q;
        for (int c = 0; c < NCOL; c++) begin
            if (col_q == c[1:0]) begin
                col_word_s = data_q[Nb-1-c*WORD -: WORD];
            end else begin
                col_word_s = col_word_s;
            end
        end
        mixed_word_s = col_mix(col_word_s);
        for (int c = 0; c < NCOL; c++) begin
            if (col_q == c[1:0]) begin
                data_mixed_s[Nb-1-c*WORD -: WORD] = mixed_word_s;
            end else begin
                data_mixed_s[Nb-1-c*WORD -: WORD] = data_q[Nb-1-c*WORD -: WORD];
            end
        end
    end

    // Next-state logic; DONE can accept a new state in the same edge it hands one off
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = state_in;
                    col_d   = 2'd0;
                    state_d = bypass ? ST_DONE : ST_MIX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MIX: begin
                data_d = data_mixed_s;
                col_d  = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MIX;
                end
            end
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    data_d  = state_in;
                    col_d   = 2'd0;
                    state_d = bypass ? ST_DONE : ST_MIX;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = 2'd0;
            end
        endcase
    end

    // State, column counter and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

    // Handshake and status decode from the state register
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_MIX:  busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign state_out = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: directed scenarios plus random
// transactions against a GF(2^8) matrix-product reference model.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         bypass;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] T1_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] T2_IN  = 128'h00112233445566778899aabbccddeeff;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bypass    (bypass),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: generic shift-and-add GF(2^8) product, then polynomial reduction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] poly;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int k = 15; k >= 8; k--) begin
            poly = 16'h011b << (k - 8);
            if (p[k]) p = p ^ poly;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic byp);
        logic [7:0]   m [4][4];
        logic [127:0] r;
        logic [7:0]   acc;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        if (byp) return s;
        r = s;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m[row][k], s[127 - 32*c - 8*k -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One transaction from IDLE; latency counted in edges including the handshake edge
    task automatic run_txn(input string tag, input logic [127:0] d, input logic byp,
                           input logic [127:0] exp, input bit garble, input int hold);
        int lat;
        bit saw_busy;
        bit ready_leak;
        bit unstable;
        @(negedge clk);
        check_val({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1'b1));
        in_valid  = 1'b1;
        state_in  = d;
        bypass    = byp;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid   = 1'b0;
        lat        = 1;
        saw_busy   = 1'b0;
        ready_leak = 1'b0;
        while (!out_valid && lat < 20) begin
            if (busy) saw_busy = 1'b1;
            if (in_ready) ready_leak = 1'b1;
            if (garble) begin
                state_in = '1;
                bypass   = 1'b1;
                in_valid = lat[0];
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_val({tag, "_latency"}, 128'(lat), byp ? 128'(1) : 128'(5));
        check_val({tag, "_busy_seen"}, 128'(saw_busy), 128'(!byp));
        check_val({tag, "_in_ready_mix"}, 128'(ready_leak), 128'(1'b0));
        check_val({tag, "_data"}, state_out, exp);
        if (hold > 0) begin
            unstable = 1'b0;
            repeat (hold) begin
                if (!out_valid || state_out !== exp || in_ready) unstable = 1'b1;
                @(negedge clk);
            end
            check_val({tag, "_hold_stable"}, 128'(unstable), 128'(1'b0));
            check_val({tag, "_data_after_hold"}, state_out, exp);
            out_ready = 1'b1;
            #1;
            check_val({tag, "_in_ready_done"}, 128'(in_ready), 128'(1'b1));
        end
        @(negedge clk);
        check_val({tag, "_out_valid_drop"}, 128'(out_valid), 128'(1'b0));
    endtask

    task automatic back_to_back();
        logic [127:0] vec [8];
        logic         vb  [8];
        logic [127:0] exp [8];
        int in_cyc [8];
        int out_cyc [8];
        int ni, no, cyc;
        bit in_hs, out_hs;
        for (int i = 0; i < 8; i++) begin
            vec[i] = (i == 0) ? T1_IN : (i == 1) ? T2_IN : rand128();
            vb[i]  = i[0];
            exp[i] = ref_mix(vec[i], vb[i]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state_in  = vec[0];
        bypass    = vb[0];
        ni = 0; no = 0; cyc = 0;
        while (no < 8 && cyc < 200) begin
            #1;
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                check_val($sformatf("b2b_data_%0d", no), state_out, exp[no]);
                out_cyc[no] = cyc;
                no++;
            end
            if (in_hs) begin
                in_cyc[ni] = cyc;
                ni++;
            end
            @(negedge clk);
            cyc++;
            if (in_hs) begin
                if (ni < 8) begin
                    state_in = vec[ni];
                    bypass   = vb[ni];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check_val("b2b_count", 128'(no), 128'(8));
        for (int i = 1; i < 8; i++) begin
            if (i < ni && i <= no)
                check_val($sformatf("b2b_no_bubble_%0d", i), 128'(in_cyc[i]), 128'(out_cyc[i-1]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet;
        rst       = 1'b1;
        in_valid  = 1'b0;
        bypass    = 1'b0;
        state_in  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_out_valid", 128'(out_valid), 128'(1'b0));
        check_val("reset_busy", 128'(busy), 128'(1'b0));
        check_val("reset_in_ready", 128'(in_ready), 128'(1'b1));
        check_val("reset_state_out", state_out, 128'h0);
        rst = 1'b0;

        run_txn("t1_mix", T1_IN, 1'b0, T1_OUT, 1'b0, 0);
        run_txn("t2_bypass", T2_IN, 1'b1, T2_IN, 1'b0, 0);
        run_txn("t3_backpressure", T1_IN, 1'b0, T1_OUT, 1'b0, 10);
        back_to_back();

        // Abort during the second MIX cycle
        @(negedge clk);
        in_valid = 1'b1;
        state_in = T1_IN;
        bypass   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("t5_rst_out_valid", 128'(out_valid), 128'(1'b0));
        check_val("t5_rst_state_out", state_out, 128'h0);
        check_val("t5_rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_val("t5_rst_busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) quiet = 1'b0;
        end
        check_val("t5_no_stale_output", 128'(quiet), 128'(1'b1));
        run_txn("t5_fresh", T1_IN, 1'b0, T1_OUT, 1'b0, 0);

        run_txn("t6_input_stability", T1_IN, 1'b0, T1_OUT, 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            logic [127:0] d;
            logic         b;
            d = rand128();
            b = 1'($urandom_range(0, 1));
            run_txn($sformatf("rand_%0d", i), d, b, ref_mix(d, b), 1'b0, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
